// File: rtl/fp_pkg.sv
// Shared floating-point constants and the handshake/conversion state machine
// encoding used by the integer converter and the double adder.
package fp_pkg;

  localparam int DBL_W    = 64;
  localparam int MANT_W   = 52;
  localparam int EXP_W    = 11;
  localparam int EXP_BIAS = 1023;

  typedef enum logic [2:0] {
    GET_A,
    CONVERT,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 53-bit significand using guard, round and sticky
// bits; a carry out renormalises the result to 1.0 and flags the exponent bump.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MANT_W:0] i_m,
  input  logic            i_g,
  input  logic            i_r,
  input  logic            i_s,
  output logic [MANT_W:0] o_m,
  output logic            o_carry
);

  logic              w_inc;
  logic [MANT_W+1:0] w_sum;

  assign w_inc   = i_g & (i_r | i_s | i_m[0]);
  assign w_sum   = {1'b0, i_m} + {{(MANT_W + 1){1'b0}}, w_inc};
  assign o_carry = w_sum[MANT_W+1];
  assign o_m     = o_carry ? {1'b1, {MANT_W{1'b0}}} : w_sum[MANT_W:0];

endmodule

// File: rtl/long_to_double.sv
// Converts a 64-bit integer into an IEEE-754 double over a stb/ack handshake,
// normalising one bit per cycle and rounding to nearest-even.
module long_to_double
  import fp_pkg::*;
#(
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DBL_W-1:0] input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  output logic [DBL_W-1:0] output_z,
  output logic             output_z_stb,
  input  logic             output_z_ack
);

  state_t             r_state,   w_stateNext;
  logic [DBL_W-1:0]   r_a,       w_aNext;
  logic [DBL_W-1:0]   r_mag,     w_magNext;
  logic [EXP_W-1:0]   r_exp,     w_expNext;
  logic               r_sign,    w_signNext;
  logic [MANT_W:0]    r_mant,    w_mantNext;
  logic [DBL_W-1:0]   r_z,       w_zNext;
  logic               r_zStb,    w_zStbNext;
  logic               r_aAck,    w_aAckNext;
  logic [MANT_W:0]    w_roundMant;
  logic               w_roundCarry;

  fp_round_rne u_round (
    .i_m     (r_mag[63:11]),
    .i_g     (r_mag[10]),
    .i_r     (r_mag[9]),
    .i_s     (|r_mag[8:0]),
    .o_m     (w_roundMant),
    .o_carry (w_roundCarry)
  );

  always_comb begin
    w_stateNext = r_state;
    w_aNext     = r_a;
    w_magNext   = r_mag;
    w_expNext   = r_exp;
    w_signNext  = r_sign;
    w_mantNext  = r_mant;
    w_zNext     = r_z;
    w_zStbNext  = r_zStb;
    w_aAckNext  = r_aAck;
    case (r_state)
      GET_A: begin
        // ack rises one edge after entering GET_A from reset, so the accept edge
        // always sees a registered ack
        if (!r_aAck) begin
          w_aAckNext = 1'b1;
        end else if (input_a_stb) begin
          w_aNext     = input_a;
          w_aAckNext  = 1'b0;
          w_stateNext = CONVERT;
        end
      end
      CONVERT: begin
        if (r_a == '0) begin
          w_zNext     = '0;
          w_zStbNext  = 1'b1;
          w_stateNext = PUT_Z;
        end else begin
          w_signNext  = (SIGNED != 0) && r_a[DBL_W-1];
          w_magNext   = w_signNext ? -r_a : r_a;
          w_expNext   = EXP_W'(63);
          w_stateNext = NORMALISE;
        end
      end
      NORMALISE: begin
        if (!r_mag[DBL_W-1]) begin
          w_magNext = r_mag << 1;
          w_expNext = r_exp - EXP_W'(1);
        end else begin
          w_stateNext = ROUND;
        end
      end
      ROUND: begin
        w_mantNext  = w_roundMant;
        w_expNext   = r_exp + {{(EXP_W - 1){1'b0}}, w_roundCarry};
        w_stateNext = PACK;
      end
      PACK: begin
        w_zNext     = {r_sign, r_exp + EXP_W'(EXP_BIAS), r_mant[MANT_W-1:0]};
        w_zStbNext  = 1'b1;
        w_stateNext = PUT_Z;
      end
      PUT_Z: begin
        if (output_z_ack) begin
          w_zStbNext  = 1'b0;
          w_aAckNext  = 1'b1;
          w_stateNext = GET_A;
        end
      end
      default: w_stateNext = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= GET_A;
      r_a     <= '0;
      r_mag   <= '0;
      r_exp   <= '0;
      r_sign  <= 1'b0;
      r_mant  <= '0;
      r_z     <= '0;
      r_zStb  <= 1'b0;
      r_aAck  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_a     <= w_aNext;
      r_mag   <= w_magNext;
      r_exp   <= w_expNext;
      r_sign  <= w_signNext;
      r_mant  <= w_mantNext;
      r_z     <= w_zNext;
      r_zStb  <= w_zStbNext;
      r_aAck  <= w_aAckNext;
    end
  end

  assign input_a_ack  = r_aAck;
  assign output_z     = r_z;
  assign output_z_stb = r_zStb;

endmodule
